// File: rtl/clk_meter_pkg.sv
// Shared types and constants for the clock period meter and its helpers.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEASURE   = 2'd1,
    TIMED_OUT = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 32;

  // All-ones value of a w-bit counter (1 <= w <= 64); saturation ceiling.
  function automatic logic [63:0] sat_max(input int w);
    return {64{1'b1}} >> (64 - w);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, plus one history flop
// for rise/fall detection. All state advances only on clken.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clkin,
  input  logic rst,
  input  logic clken,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  // Shift the async input through the synchronizer and remember last level.
  always_ff @(posedge clkin) begin
    if (rst) begin
      chain <= '0;
      hist  <= 1'b0;
    end else if (clken) begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      hist  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clkin
// cycles, flags loss of edges (timeout) and lock against an expected period.
// Optional build macro CLK_METER_AVG_EN adds period_avg, the mean of the last
// four measured periods (0 until four have been taken).
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT     = 50000000,
  parameter int EXPECTED    = 50000,
  parameter int TOL         = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             clken,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout,
  output logic             locked
`ifdef CLK_METER_AVG_EN
  , output logic [CNT_W-1:0] period_avg
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] EXP_C     = CNT_W'(EXPECTED);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam int               RUN_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] LOCK_C    = RUN_W'(LOCK_COUNT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Absolute difference without wrap-around, compared against the tolerance.
  function automatic logic in_tol(input logic [CNT_W-1:0] p);
    if (p >= EXP_C) return (p - EXP_C) <= TOL_C;
    else            return (EXP_C - p) <= TOL_C;
  endfunction

  logic             level, rise, fall;
  state_t           state;
  logic [CNT_W-1:0] cnt, hcnt, hi_shadow, cnt_inc;
  logic             mv_p1;
  logic [RUN_W-1:0] lock_run, run_inc;
  logic             meas_evt, to_evt, tol_ok;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clkin (clkin),
    .rst   (rst),
    .clken (clken),
    .d     (sig_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // cnt_inc is the period length if a rise lands this cycle (the rise cycle
  // itself is the last cycle of the period).
  assign cnt_inc  = sat_inc(cnt);
  assign meas_evt = clken && (state == MEASURE) && rise;
  assign to_evt   = clken && (state == MEASURE) && !rise && (cnt_inc == TIMEOUT_C);
  assign tol_ok   = in_tol(cnt_inc);
  assign run_inc  = (lock_run == LOCK_C) ? lock_run : lock_run + RUN_W'(1);

  // The pulse is held while disabled and shown only in enabled cycles, so a
  // consumer in the clken domain sees it exactly once.
  assign meas_valid = mv_p1 & clken;

  // Edge-to-edge measurement FSM.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      hi_shadow <= '0;
      period    <= '0;
      high_time <= '0;
      mv_p1     <= 1'b0;
      timeout   <= 1'b0;
    end else if (clken) begin
      mv_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= '0;
            hcnt  <= '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period    <= cnt_inc;
            high_time <= hi_shadow;
            mv_p1     <= 1'b1;
            cnt       <= '0;
            hcnt      <= '0;
          end else if (cnt_inc == TIMEOUT_C) begin
            state   <= TIMED_OUT;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt_inc;
            if (level) hcnt <= sat_inc(hcnt);
            // hcnt misses the rise cycle (it restarts at 0 there), so add it back.
            if (fall) hi_shadow <= sat_inc(hcnt);
          end
        end
        TIMED_OUT: begin
          if (rise) begin
            state   <= MEASURE;
            timeout <= 1'b0;
            cnt     <= '0;
            hcnt    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lock tracking: consecutive in-tolerance measurements, cleared on timeout.
  always_ff @(posedge clkin) begin
    if (rst || to_evt) begin
      lock_run <= '0;
      locked   <= 1'b0;
    end else if (meas_evt) begin
      if (tol_ok) begin
        lock_run <= run_inc;
        locked   <= (run_inc == LOCK_C);
      end else begin
        lock_run <= '0;
        locked   <= 1'b0;
      end
    end
  end

`ifdef CLK_METER_AVG_EN
  logic [CNT_W-1:0] hist [4];
  logic [CNT_W+1:0] sum, sum_next;
  logic [2:0]       navg;

  // Running sum: add the newest period, drop the one leaving the window.
  assign sum_next = sum + {2'b00, cnt_inc} - {2'b00, hist[3]};

  // Four-deep period history and its average, published with meas_valid.
  always_ff @(posedge clkin) begin
    if (rst || to_evt) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      sum        <= '0;
      navg       <= '0;
      period_avg <= '0;
    end else if (meas_evt) begin
      hist[0] <= cnt_inc;
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      sum <= sum_next;
      if (navg != 3'd4) navg <= navg + 3'd1;
      period_avg <= (navg >= 3'd3) ? sum_next[CNT_W+1:2] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: square-wave measurement, lock,
// out-of-tolerance, timeout, clken gating, mid-period reset and (with
// CLK_METER_AVG_EN) the moving average.
module tb_clk_period_meter;

  localparam int CNT_W = 16;

  logic             clkin  = 1'b0;
  logic             rst    = 1'b1;
  logic             clken  = 1'b1;
  logic             sig_in = 1'b0;
  logic             meas_valid;
  logic [CNT_W-1:0] period, high_time;
  logic             timeout, locked;
`ifdef CLK_METER_AVG_EN
  logic [CNT_W-1:0] period_avg;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rise_cyc = 0;
  int   to_cyc = -1;
  int   mv_off = 0;
  logic prev_to = 1'b0;
  logic tog = 1'b0;
  int   q_per[$];
  int   q_hi[$];
  int   q_lck[$];
  int   q_avg[$];

  clk_period_meter #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W),
    .TIMEOUT    (100),
    .EXPECTED   (20),
    .TOL        (1),
    .LOCK_COUNT (4)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
    .clken     (clken),
    .sig_in    (sig_in),
    .meas_valid(meas_valid),
    .period    (period),
    .high_time (high_time),
    .timeout   (timeout),
    .locked    (locked)
`ifdef CLK_METER_AVG_EN
    , .period_avg(period_avg)
`endif
  );

  always #5 clkin = ~clkin;

  function automatic int qp(input int i);
    return (i < q_per.size()) ? q_per[i] : -1;
  endfunction
  function automatic int qh(input int i);
    return (i < q_hi.size()) ? q_hi[i] : -1;
  endfunction
  function automatic int ql(input int i);
    return (i < q_lck.size()) ? q_lck[i] : -1;
  endfunction
  function automatic int qa(input int i);
    return (i < q_avg.size()) ? q_avg[i] : -1;
  endfunction

  // One clkin cycle: sample outputs at the falling edge, then drive inputs.
  task automatic step(input logic s, input logic en);
    @(negedge clkin);
    cyc++;
    if (meas_valid === 1'b1) begin
      q_per.push_back(int'(period));
      q_hi.push_back(int'(high_time));
      q_lck.push_back(int'(locked));
`ifdef CLK_METER_AVG_EN
      q_avg.push_back(int'(period_avg));
`endif
      if (clken !== 1'b1) mv_off++;
    end
    if (timeout === 1'b1 && prev_to !== 1'b1) to_cyc = cyc;
    prev_to = timeout;
    if (s && !sig_in) last_rise_cyc = cyc;
    sig_in = s;
    clken  = en;
  endtask

  task automatic wave(input int hi, input int lo, input int n, input bit alt);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) begin step(1'b1, alt ? tog : 1'b1); tog = ~tog; end
      for (int i = 0; i < lo; i++) begin step(1'b0, alt ? tog : 1'b1); tog = ~tog; end
    end
  endtask

  task automatic clear_q();
    q_per.delete(); q_hi.delete(); q_lck.delete(); q_avg.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL rst_period: got %0d want 0", period); end
    checks++; if (high_time !== 16'd0) begin errors++; $display("FAIL rst_high: got %0d want 0", high_time); end
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL rst_mv: got %b want 0", meas_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b want 0", locked); end
    rst = 1'b0;
  endtask

  task automatic test_square();
    repeat (5) step(1'b0, 1'b1);
    clear_q();
    wave(10, 10, 6, 1'b0);
    checks++; if (q_per.size() !== 5) begin errors++; $display("FAIL sq_count: got %0d want 5", q_per.size()); end
    checks++; if (qp(0) !== 20) begin errors++; $display("FAIL sq_period0: got %0d want 20", qp(0)); end
    checks++; if (qp(4) !== 20) begin errors++; $display("FAIL sq_period4: got %0d want 20", qp(4)); end
    checks++; if (qh(0) !== 10) begin errors++; $display("FAIL sq_high0: got %0d want 10", qh(0)); end
    checks++; if (qh(4) !== 10) begin errors++; $display("FAIL sq_high4: got %0d want 10", qh(4)); end
    checks++; if (ql(2) !== 0) begin errors++; $display("FAIL sq_lock3rd: got %0d want 0", ql(2)); end
    checks++; if (ql(3) !== 1) begin errors++; $display("FAIL sq_lock4th: got %0d want 1", ql(3)); end
  endtask

  task automatic test_out_of_tol();
    clear_q();
    wave(10, 13, 1, 1'b0);
    wave(10, 10, 5, 1'b0);
    checks++; if (q_per.size() !== 6) begin errors++; $display("FAIL oot_count: got %0d want 6", q_per.size()); end
    checks++; if (qp(1) !== 23) begin errors++; $display("FAIL oot_period: got %0d want 23", qp(1)); end
    checks++; if (qh(1) !== 10) begin errors++; $display("FAIL oot_high: got %0d want 10", qh(1)); end
    checks++; if (ql(1) !== 0) begin errors++; $display("FAIL oot_unlock: got %0d want 0", ql(1)); end
    checks++; if (qp(2) !== 20) begin errors++; $display("FAIL oot_period_after: got %0d want 20", qp(2)); end
    checks++; if (ql(4) !== 0) begin errors++; $display("FAIL oot_lock3rd: got %0d want 0", ql(4)); end
    checks++; if (ql(5) !== 1) begin errors++; $display("FAIL oot_relock: got %0d want 1", ql(5)); end
  endtask

  task automatic test_timeout();
    to_cyc = -1;
    repeat (150) step(1'b0, 1'b1);
    // TIMEOUT enabled cycles after the rise is seen, which is 3 cycles after sig_in moves.
    checks++; if (to_cyc - last_rise_cyc !== 103) begin errors++; $display("FAIL to_delay: got %0d want 103", to_cyc - last_rise_cyc); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", timeout); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL to_locked: got %b want 0", locked); end
    checks++; if (period !== 16'd20) begin errors++; $display("FAIL to_period_kept: got %0d want 20", period); end
    clear_q();
    wave(10, 10, 1, 1'b0);
    checks++; if (q_per.size() !== 0) begin errors++; $display("FAIL to_no_meas: got %0d want 0", q_per.size()); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_cleared: got %b want 0", timeout); end
    wave(10, 10, 1, 1'b0);
    checks++; if (q_per.size() !== 1) begin errors++; $display("FAIL to_resume_count: got %0d want 1", q_per.size()); end
    checks++; if (qp(0) !== 20) begin errors++; $display("FAIL to_resume_period: got %0d want 20", qp(0)); end
    checks++; if (qh(0) !== 10) begin errors++; $display("FAIL to_resume_high: got %0d want 10", qh(0)); end
  endtask

  task automatic test_clken();
    clear_q();
    mv_off = 0;
    tog = 1'b1;
    wave(20, 20, 5, 1'b1);
    step(1'b0, 1'b1);
    checks++; if (q_per.size() !== 5) begin errors++; $display("FAIL ce_count: got %0d want 5", q_per.size()); end
    checks++; if (qp(1) !== 20) begin errors++; $display("FAIL ce_period1: got %0d want 20", qp(1)); end
    checks++; if (qp(4) !== 20) begin errors++; $display("FAIL ce_period4: got %0d want 20", qp(4)); end
    checks++; if (qh(4) !== 10) begin errors++; $display("FAIL ce_high4: got %0d want 10", qh(4)); end
    checks++; if (ql(4) !== 1) begin errors++; $display("FAIL ce_locked: got %0d want 1", ql(4)); end
    checks++; if (mv_off !== 0) begin errors++; $display("FAIL ce_mv_while_off: got %0d want 0", mv_off); end
  endtask

  task automatic test_rst_mid();
    repeat (10) step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b1);
    rst = 1'b0;
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL rm_period: got %0d want 0", period); end
    checks++; if (high_time !== 16'd0) begin errors++; $display("FAIL rm_high: got %0d want 0", high_time); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rm_locked: got %b want 0", locked); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rm_timeout: got %b want 0", timeout); end
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL rm_mv: got %b want 0", meas_valid); end
    clear_q();
    repeat (5) step(1'b0, 1'b1);
    wave(10, 10, 1, 1'b0);
    checks++; if (q_per.size() !== 0) begin errors++; $display("FAIL rm_first_edge: got %0d want 0", q_per.size()); end
    wave(10, 10, 1, 1'b0);
    checks++; if (q_per.size() !== 1) begin errors++; $display("FAIL rm_second_edge: got %0d want 1", q_per.size()); end
    checks++; if (qp(0) !== 20) begin errors++; $display("FAIL rm_period: got %0d want 20", qp(0)); end
  endtask

`ifdef CLK_METER_AVG_EN
  task automatic test_avg();
    rst = 1'b1;
    step(1'b0, 1'b1);
    rst = 1'b0;
    clear_q();
    wave(10, 10, 2, 1'b0);
    wave(10, 12, 2, 1'b0);
    wave(10, 10, 1, 1'b0);
    checks++; if (q_avg.size() !== 4) begin errors++; $display("FAIL avg_count: got %0d want 4", q_avg.size()); end
    checks++; if (qa(0) !== 0) begin errors++; $display("FAIL avg_first: got %0d want 0", qa(0)); end
    checks++; if (qa(2) !== 0) begin errors++; $display("FAIL avg_third: got %0d want 0", qa(2)); end
    checks++; if (qp(3) !== 22) begin errors++; $display("FAIL avg_period4: got %0d want 22", qp(3)); end
    checks++; if (qa(3) !== 21) begin errors++; $display("FAIL avg_fourth: got %0d want 21", qa(3)); end
  endtask
`endif

  initial begin
    test_reset();
    test_square();
    test_out_of_tol();
    test_timeout();
    test_clken();
    test_rst_mid();
`ifdef CLK_METER_AVG_EN
    test_avg();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
